// File: rtl/mult_issue_queue.sv
// Operand FIFO and issue controller in front of the add-loop multiplier, with a valid/ready result register.
// Optional build macro MULT_OPERAND_SWAP_EN issues the smaller operand as the loop count.
//
// state  | meaning
// S_IDLE | waiting for a queued pair, an idle multiplier and room in the result register
// S_BUSY | start issued; multiplier still echoing rdy from the start cycle
// S_WAIT | multiplier running; capture product when rdy returns
module mult_issue_queue #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4
) (
    input  logic                      clk,
    input  logic                      rst_b,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_WIDTH-1:0]     in_a,
    input  logic [DATA_WIDTH-1:0]     in_b,
    output logic                      mul_start,
    output logic [DATA_WIDTH-1:0]     mul_a,
    output logic [DATA_WIDTH-1:0]     mul_b,
    input  logic                      mul_rdy,
    input  logic [2*DATA_WIDTH-1:0]   mul_p,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic [2*DATA_WIDTH-1:0]   res_p,
    output logic [$clog2(DEPTH):0]    level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;

    logic [DATA_WIDTH-1:0]     r_mem_a [DEPTH];
    logic [DATA_WIDTH-1:0]     r_mem_b [DEPTH];
    logic [AW-1:0]             r_wr_ptr;
    logic [AW-1:0]             r_rd_ptr;
    logic [LW-1:0]             r_level;

    logic                      r_res_valid;
    logic [2*DATA_WIDTH-1:0]   r_res_p;

    logic                      w_push;
    logic                      w_pop;
    logic                      w_empty;
    logic                      w_full;
    logic                      w_issue;
    logic                      w_capture;
    logic [DATA_WIDTH-1:0]     w_head_a;
    logic [DATA_WIDTH-1:0]     w_head_b;

    assign w_full   = (r_level == LW'(DEPTH));
    assign w_empty  = (r_level == '0);
    assign w_push   = in_valid && !w_full;
    assign w_pop    = w_issue;
    assign w_head_a = r_mem_a[r_rd_ptr];
    assign w_head_b = r_mem_b[r_rd_ptr];

    // Storage is cleared on reset so the head reads 0 before the first push.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_a[i] <= '0;
                r_mem_b[i] <= '0;
            end
        end else if (w_push) begin
            r_mem_a[r_wr_ptr] <= in_a;
            r_mem_b[r_wr_ptr] <= in_b;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty && mul_rdy && (!r_res_valid || res_ready)) begin
                    w_issue     = 1'b1;
                    w_state_nxt = S_BUSY;
                end
            end
            S_BUSY: begin
                // rdy seen here is the start-cycle echo; only its fall matters.
                if (!mul_rdy) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mul_rdy) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // A capture in the same cycle as a downstream accept wins and keeps valid high.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_res_valid <= 1'b0;
            r_res_p     <= '0;
        end else if (w_capture) begin
            r_res_valid <= 1'b1;
            r_res_p     <= mul_p;
        end else if (r_res_valid && res_ready) begin
            r_res_valid <= 1'b0;
        end
    end

`ifdef MULT_OPERAND_SWAP_EN
    logic w_swap;

    // Equal operands leave the pair as queued.
    assign w_swap = (w_head_b < w_head_a);
    assign mul_a  = w_swap ? w_head_b : w_head_a;
    assign mul_b  = w_swap ? w_head_a : w_head_b;
`else
    assign mul_a  = w_head_a;
    assign mul_b  = w_head_b;
`endif

    assign in_ready  = !w_full;
    assign mul_start = w_issue;
    assign res_valid = r_res_valid;
    assign res_p     = r_res_p;
    assign level     = r_level;

endmodule

// File: tb/tb_mult_issue_queue.sv
// Bench for mult_issue_queue: an add-loop multiplier model, a queue-level reference model checked every cycle,
// and directed vectors with literal expected products and latencies.
module tb_mult_issue_queue;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic            clk = 1'b0;
    logic            rst_b = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [DW-1:0]   in_a = '0;
    logic [DW-1:0]   in_b = '0;
    logic            mul_start;
    logic [DW-1:0]   mul_a;
    logic [DW-1:0]   mul_b;
    logic            mul_rdy;
    logic [2*DW-1:0] mul_p;
    logic            res_valid;
    logic            res_ready = 1'b0;
    logic [2*DW-1:0] res_p;
    logic [LW-1:0]   level;

    mult_issue_queue #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_b(rst_b),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
        .mul_rdy(mul_rdy), .mul_p(mul_p),
        .res_valid(res_valid), .res_ready(res_ready), .res_p(res_p),
        .level(level)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual=timeout required=event", name);
    endtask

    // Add-loop multiplier: loads A as loop count, rdy low for A+1 cycles, product accumulates B.
    logic            mb_busy;
    logic [DW-1:0]   mb_cnt;
    logic [2*DW-1:0] mb_acc;
    logic [2*DW-1:0] mb_b;

    always @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            mb_busy <= 1'b0;
            mb_cnt  <= '0;
            mb_acc  <= '0;
            mb_b    <= '0;
        end else if (mul_start && !mb_busy) begin
            mb_busy <= 1'b1;
            mb_cnt  <= mul_a;
            mb_b    <= {{DW{1'b0}}, mul_b};
            mb_acc  <= '0;
        end else if (mb_busy) begin
            if (mb_cnt == 0) begin
                mb_busy <= 1'b0;
            end else begin
                mb_acc <= mb_acc + mb_b;
                mb_cnt <= mb_cnt - 1'b1;
            end
        end
    end

    assign mul_rdy = !mb_busy;
    assign mul_p   = mb_acc;

    // Reference model: queued pairs, one job in flight, one result slot.
    typedef struct {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
    } pair_t;

    pair_t           mq[$];
    bit              m_inflight = 0;
    bit              m_seen_low = 0;
    bit              m_res_valid = 0;
    logic [2*DW-1:0] m_res_p = '0;
    logic [2*DW-1:0] m_job_p = '0;

    int              cyc = 0;
    int              n_start = 0;
    int              last_push_cyc = -1;
    int              last_start_cyc = -1;
    int              res_rise_cyc = -1;
    logic [2*DW-1:0] res_rise_p = '0;
    logic            prev_res_valid = 1'b0;
    logic [2*DW-1:0] got[$];

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    always @(negedge clk) begin
        bit            exp_issue;
        bit            push_ok;
        bit            capture;
        logic [DW-1:0] ea;
        logic [DW-1:0] eb;
        if (!rst_b) begin
            mq.delete();
            m_inflight     = 0;
            m_seen_low     = 0;
            m_res_valid    = 0;
            m_res_p        = '0;
            prev_res_valid = 1'b0;
            check("rst_res_valid", res_valid, 0);
            check("rst_level", level, 0);
        end else begin
            exp_issue = (mq.size() > 0) && !m_inflight && mul_rdy && (!m_res_valid || res_ready);
            push_ok   = in_valid && (mq.size() != DEPTH);
            check("level", level, mq.size());
            check("in_ready", in_ready, mq.size() != DEPTH);
            check("mul_start", mul_start, exp_issue);
            check("res_valid", res_valid, m_res_valid);
            if (m_res_valid) check("res_p", res_p, m_res_p);
            if (mq.size() > 0) begin
                ea = mq[0].a;
                eb = mq[0].b;
`ifdef MULT_OPERAND_SWAP_EN
                if (mq[0].b < mq[0].a) begin
                    ea = mq[0].b;
                    eb = mq[0].a;
                end
`endif
                check("mul_a", mul_a, ea);
                check("mul_b", mul_b, eb);
            end

            if (in_valid && in_ready) last_push_cyc = cyc;
            if (mul_start) begin
                last_start_cyc = cyc;
                n_start++;
            end
            if (res_valid && !prev_res_valid) begin
                res_rise_cyc = cyc;
                res_rise_p   = res_p;
            end
            prev_res_valid = res_valid;
            if (res_valid && res_ready) got.push_back(res_p);

            capture = m_inflight && m_seen_low && mul_rdy;
            if (m_inflight && !mul_rdy) m_seen_low = 1;
            if (capture) begin
                m_inflight  = 0;
                m_res_valid = 1;
                m_res_p     = m_job_p;
            end else if (m_res_valid && res_ready) begin
                m_res_valid = 0;
            end
            if (exp_issue) begin
                m_job_p    = (2*DW)'(mq[0].a) * (2*DW)'(mq[0].b);
                m_inflight = 1;
                m_seen_low = 0;
                void'(mq.pop_front());
            end
            if (push_ok) mq.push_back('{a: in_a, b: in_b});
        end
    end

    task automatic push(input logic [DW-1:0] a, input logic [DW-1:0] b);
        int n = 0;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 300) begin
                fail_now("push_wait");
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_result(input string name, input int exp_p, input int exp_delta);
        int n = 0;
        while (res_rise_cyc <= last_push_cyc && n < 400) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (res_rise_cyc <= last_push_cyc) begin
            fail_now({name, "_timeout"});
        end else begin
            check({name, "_start_lat"}, last_start_cyc - last_push_cyc, 1);
            check({name, "_res_lat"}, res_rise_cyc - last_push_cyc, exp_delta);
            check({name, "_p"}, res_rise_p, exp_p);
        end
    endtask

    int exp_bp[5] = '{1, 4, 9, 16, 25};

    initial begin
        int n;
        int s0;
        int rise0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_in_ready", in_ready, 1);
        check("reset_res_valid", res_valid, 0);
        check("reset_res_p", res_p, 0);
        check("reset_level", level, 0);
        check("reset_mul_start", mul_start, 0);
        check("reset_mul_a", mul_a, 0);
        check("reset_mul_b", mul_b, 0);
        rst_b = 1'b1;
        res_ready = 1'b1;

        push(8'd3, 8'd5);
        wait_result("j3x5", 15, 7);
        push(8'd200, 8'd2);
`ifdef MULT_OPERAND_SWAP_EN
        wait_result("j200x2", 400, 6);
`else
        wait_result("j200x2", 400, 204);
`endif
        push(8'd0, 8'd9);
        wait_result("j0x9", 0, 4);
        push(8'd255, 8'd255);
        wait_result("j255x255", 65025, 259);

        repeat (3) @(posedge clk);
        #1;
        res_ready = 1'b0;
        s0 = n_start;
        for (int i = 1; i <= 5; i++) push(DW'(i), DW'(i));
        repeat (20) @(posedge clk);
        #1;
        check("bp_level", level, 4);
        check("bp_in_ready", in_ready, 0);
        check("bp_starts", n_start - s0, 1);
        check("bp_res_valid", res_valid, 1);
        check("bp_res_p", res_p, 1);
        got.delete();
        res_ready = 1'b1;
        n = 0;
        while (got.size() < 5 && n < 300) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (got.size() < 5) begin
            fail_now("bp_drain");
        end else begin
            for (int i = 0; i < 5; i++) check("bp_order", got[i], exp_bp[i]);
        end

        push(8'd10, 8'd10);
        repeat (5) @(posedge clk);
        #1;
        rst_b = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("midrst_res_valid", res_valid, 0);
        check("midrst_level", level, 0);
        check("midrst_mul_start", mul_start, 0);
        rise0 = res_rise_cyc;
        rst_b = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("midrst_no_result", res_rise_cyc, rise0);
        check("midrst_res_valid_after", res_valid, 0);
        push(8'd2, 8'd3);
        wait_result("j2x3", 6, 6);

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
